shift_reg_ctrl: RTL

//   Sequencer for a WIDTH-bit parallel-load / serial-shift register (load, shift, I, SI, SO, A).

---
 rtl/shift_reg_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/shift_reg_ctrl.sv
// Sequencer for a parallel-load / serial-shift register. It takes one word per start/busy/done
// handshake and drives the register's load and shift enables to transmit or receive that word.
//   state   | meaning
//   S_IDLE  | waiting for start; latches din/mode and clears the shift counter
//   S_LOAD  | one-cycle parallel load of the latched word (transmit only)
//   S_SHIFT | one shift per cycle unless hold is high; leaves after WIDTH shifts
//   S_DONE  | one-cycle completion pulse; captures the register's parallel output
module shift_reg_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  input  logic             hold,
  input  logic [WIDTH-1:0] a_in,
  output logic             load,
  output logic             shift,
  output logic [WIDTH-1:0] i_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(WIDTH);

  state_t             r_state;
  state_t             w_next;
  logic               r_mode_q;
  logic [WIDTH-1:0]   r_i;
  logic [WIDTH-1:0]   r_dout;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_accept;

  assign w_accept = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    load   = 1'b0;
    shift  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = mode ? S_SHIFT : S_LOAD;
        end
      end
      S_LOAD: begin
        // LOAD is only reachable in transmit mode; gating on the latched mode keeps a receive
        // from ever clobbering the register with a stale word.
        load   = ~r_mode_q;
        busy   = 1'b1;
        w_next = S_SHIFT;
      end
      S_SHIFT: begin
        busy  = 1'b1;
        shift = ~hold;
        if (!hold && (r_cnt == LP_LAST)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mode_q <= 1'b0;
      r_i      <= '0;
      r_cnt    <= '0;
      r_dout   <= '0;
    end else begin
      if (w_accept) begin
        r_i      <= din;
        r_mode_q <= mode;
        r_cnt    <= '0;
      end else if (shift && (r_cnt != LP_FULL)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == S_DONE) begin
        r_dout <= a_in;
      end
    end
  end

  assign i_out   = r_i;
  assign dout    = r_dout;
  assign bit_cnt = r_cnt;

endmodule
